// File: rtl/e1of2_chan_rx.sv
// rtl/e1of2_chan_rx.sv - e1of2 dual-rail channel receiver feeding a show-ahead valid/ready FIFO
module e1of2_chan_rx #(
    parameter int M           = 7,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic           CLK,
    input  logic           _RESET,
    input  logic [2*M-1:0] ch_d,
    output logic           ch_e,
    output logic [M-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           err_illegal
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic S_WAIT_NEUTRAL = 1'b0;
    localparam logic S_WAIT_DATA    = 1'b1;

    logic [2*M-1:0]       sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill_q;
    logic [2*M-1:0]       ds;
    logic                 fill_ok;

    logic                 all_valid;
    logic                 all_neutral;
    logic                 illegal;
    logic [M-1:0]         word;

    logic                 state;
    logic                 push;
    logic                 pop;

    logic [M-1:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;

    // fill_q marks when the freshly cleared chain has been refilled from the live rails
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            fill_q <= '0;
        end else begin
            sync_q[0] <= ch_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign ds      = sync_q[SYNC_STAGES-1];
    assign fill_ok = fill_q[SYNC_STAGES-1];

    always_comb begin
        all_valid   = 1'b1;
        all_neutral = (ds == '0);
        illegal     = 1'b0;
        word        = '0;
        for (int i = 0; i < M; i++) begin
            word[i] = ds[2*i+1];
            if (ds[2*i] == ds[2*i+1]) begin
                all_valid = 1'b0;
            end
            if (ds[2*i] && ds[2*i+1]) begin
                illegal = 1'b1;
            end
        end
    end

    assign push      = (state == S_WAIT_DATA) && all_valid;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state       <= S_WAIT_NEUTRAL;
            ch_e        <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            if (illegal) begin
                err_illegal <= 1'b1;
            end
            case (state)
                S_WAIT_NEUTRAL: begin
                    // registered count: a pop this cycle re-enables one cycle later
                    if (fill_ok && all_neutral && (count < DEPTH_C)) begin
                        ch_e  <= 1'b1;
                        state <= S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    if (all_valid) begin
                        ch_e  <= 1'b0;
                        state <= S_WAIT_NEUTRAL;
                    end
                end
                default: begin
                    ch_e  <= 1'b0;
                    state <= S_WAIT_NEUTRAL;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
